// File: rtl/hidden_delta_engine_pkg.sv
// hidden_delta_pkg: shared types and helpers for hidden_delta_engine.
//   state_e  - controller states
//   ONE      - fixed-point 1.0 for the default format (W=10, FRAC=6)
//   ACC_W    - MAC accumulator width for the default sizing
//   sat_w()  - clip a wide signed value into a signed field of 'width' bits
package hidden_delta_pkg;

    typedef enum logic [2:0] {IDLE, MAC, SCALE, EMIT, DONE} state_e;

    localparam int DEF_W     = 10;
    localparam int DEF_FRAC  = 6;
    localparam int DEF_N_OUT = 3;
    localparam int ONE       = 1 << DEF_FRAC;
    localparam int ACC_W     = 2 * DEF_W + $clog2(DEF_N_OUT);

    typedef struct packed {
        logic signed [63:0] val;
        logic               flag;
    } sat_t;

    function automatic sat_t sat_w(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               res;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        res.val  = value;
        res.flag = 1'b0;
        if (value > hi) begin
            res.val  = hi;
            res.flag = 1'b1;
        end else if (value < lo) begin
            res.val  = lo;
            res.flag = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hidden_delta_engine_if.sv
// hidden_delta_engine_if: job request and result stream of hidden_delta_engine.
//   master: drives start, operands and out_ready; observes status and beats.
//   slave : the engine side.
interface hidden_delta_engine_if #(
    parameter int W        = 10,
    parameter int N_HIDDEN = 5,
    parameter int N_OUT    = 3
);
    localparam int IW = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;

    logic                        start;
    logic [N_OUT*W-1:0]          delta1_i;
    logic [N_OUT*N_HIDDEN*W-1:0] weight_i;
    logic [N_HIDDEN*W-1:0]       act_i;
    logic                        busy;
    logic                        out_valid;
    logic                        out_ready;
    logic [IW-1:0]               out_idx;
    logic signed [W-1:0]         out_delta;
    logic                        sat_flag;
    logic                        done;

    modport master (
        output start, delta1_i, weight_i, act_i, out_ready,
        input  busy, out_valid, out_idx, out_delta, sat_flag, done
    );

    modport slave (
        input  start, delta1_i, weight_i, act_i, out_ready,
        output busy, out_valid, out_idx, out_delta, sat_flag, done
    );
endinterface

// File: rtl/hidden_delta_engine_scale.sv
// fxp_deriv_scale: combinational scale step for one hidden neuron.
//   i_acc   - signed sum_k delta1[k]*W[k][j] (2*FRAC fractional bits)
//   i_act   - unsigned activation out0[j]
//   o_delta - saturated f'(act) * (acc >>> FRAC), W-bit signed
//   o_sat   - result was clipped
module fxp_deriv_scale
    import hidden_delta_pkg::*;
#(
    parameter int W     = 10,
    parameter int FRAC  = 6,
    parameter int ACC_W = 22
) (
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [W-1:0]     i_act,
    output logic signed [W-1:0]     o_delta,
    output logic                    o_sat
);
    localparam logic signed [63:0] L_ONE = 64'sd1 <<< FRAC;

    logic signed [63:0] w_s;
    logic signed [63:0] w_act;
    logic signed [63:0] w_a;
    logic signed [63:0] w_d;
    logic signed [63:0] w_r;
    sat_t               w_res;

    always_comb begin
        w_s   = 64'(i_acc) >>> FRAC;
        w_act = 64'(i_act);
        // Activations above 1.0 are clamped, which makes the derivative 0.
        w_a   = (w_act > L_ONE) ? L_ONE : w_act;
        w_d   = (w_a * (L_ONE - w_a)) >>> FRAC;
        w_r   = (w_s * w_d) >>> FRAC;
        w_res = sat_w(w_r, W);
        o_delta = W'(w_res.val);
        o_sat   = w_res.flag;
    end
endmodule

// File: rtl/hidden_delta_engine.sv
// hidden_delta_engine: sequential hidden-layer delta calculator.
//   clk, rst_n - clock, async active-low reset
//   io_bus     - slave side of hidden_delta_engine_if: start/busy/done control,
//                latched operands, and one (out_idx, out_delta, sat_flag) beat
//                per hidden neuron on a valid/ready stream.
// One shared multiplier accumulates N_OUT terms per neuron, then the scale
// step applies f'(a) = a*(1-a) and saturates.
module hidden_delta_engine
    import hidden_delta_pkg::*;
#(
    parameter int W        = 10,
    parameter int FRAC     = 6,
    parameter int N_HIDDEN = 5,
    parameter int N_OUT    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hidden_delta_engine_if.slave  io_bus
);
    localparam int ACC_L = 2 * W + $clog2(N_OUT);
    localparam int JW    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam int KW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WIX   = (N_OUT * N_HIDDEN > 1) ? $clog2(N_OUT * N_HIDDEN) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(N_HIDDEN - 1);
    localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

    state_e                                r_state;
    logic [N_OUT-1:0][W-1:0]               r_d1;
    logic [N_OUT*N_HIDDEN-1:0][W-1:0]      r_wt;
    logic [N_HIDDEN-1:0][W-1:0]            r_act;
    logic [JW-1:0]                         r_j;
    logic [KW-1:0]                         r_k;
    logic signed [ACC_L-1:0]               r_acc;
    logic                                  r_busy;
    logic                                  r_valid;
    logic                                  r_done;
    logic                                  r_sat;
    logic [JW-1:0]                         r_idx;
    logic signed [W-1:0]                   r_delta;

    logic [WIX-1:0]      w_widx;
    logic signed [W-1:0] w_d1_k;
    logic signed [W-1:0] w_wt_kj;
    logic signed [2*W-1:0] w_prod;
    logic signed [W-1:0] w_delta;
    logic                w_sat;

    // W[k][j] lives at flat element k*N_HIDDEN + j.
    assign w_widx  = WIX'(int'(r_k) * N_HIDDEN + int'(r_j));
    assign w_d1_k  = r_d1[r_k];
    assign w_wt_kj = r_wt[w_widx];
    assign w_prod  = w_d1_k * w_wt_kj;

    fxp_deriv_scale #(.W(W), .FRAC(FRAC), .ACC_W(ACC_L)) u_scale (
        .i_acc   (r_acc),
        .i_act   (r_act[r_j]),
        .o_delta (w_delta),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_d1    <= '0;
            r_wt    <= '0;
            r_act   <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
            r_idx   <= '0;
            r_delta <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_d1    <= io_bus.delta1_i;
                        r_wt    <= io_bus.weight_i;
                        r_act   <= io_bus.act_i;
                        r_j     <= '0;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + ACC_L'(w_prod);
                    if (r_k == K_LAST) begin
                        r_k     <= '0;
                        r_state <= SCALE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                SCALE: begin
                    // Beat is registered and presented in the same step.
                    r_delta <= w_delta;
                    r_sat   <= w_sat;
                    r_idx   <= r_j;
                    r_valid <= 1'b1;
                    r_state <= EMIT;
                end
                EMIT: begin
                    if (io_bus.out_ready) begin
                        r_valid <= 1'b0;
                        if (r_j == J_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_j     <= r_j + JW'(1);
                            r_k     <= '0;
                            r_acc   <= '0;
                            r_state <= MAC;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.out_valid = r_valid;
    assign io_bus.done      = r_done;
    assign io_bus.sat_flag  = r_sat;
    assign io_bus.out_idx   = r_idx;
    assign io_bus.out_delta = r_delta;
endmodule

// File: tb/tb_hidden_delta_engine.sv
// Directed bench for hidden_delta_engine with hand-computed expected deltas.
module tb_hidden_delta_engine;
    localparam int W  = 10;
    localparam int NH = 5;
    localparam int NO = 3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   exp_d [NH];
    int   exp_s [NH];

    hidden_delta_engine_if #(.W(W), .N_HIDDEN(NH), .N_OUT(NO)) bus ();

    hidden_delta_engine #(.W(W), .FRAC(6), .N_HIDDEN(NH), .N_OUT(NO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_data(input int d1, input int wt, input int a);
        logic [W-1:0] t;
        for (int k = 0; k < NO; k++) begin
            t = W'(d1);
            bus.delta1_i[k*W +: W] = t;
        end
        for (int i = 0; i < NO * NH; i++) begin
            t = W'(wt);
            bus.weight_i[i*W +: W] = t;
        end
        for (int j = 0; j < NH; j++) begin
            t = W'(a);
            bus.act_i[j*W +: W] = t;
        end
    endtask

    task automatic set_exp(input int d, input int s);
        for (int j = 0; j < NH; j++) begin
            exp_d[j] = d;
            exp_s[j] = s;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_valid"}, int'(bus.out_valid), 0);
        check({tag, "_done"},  int'(bus.done), 0);
        check({tag, "_sat"},   int'(bus.sat_flag), 0);
        check({tag, "_idx"},   int'(bus.out_idx), 0);
        check({tag, "_delta"}, int'($signed(bus.out_delta)), 0);
    endtask

    // Runs one job: start in cycle 0, optional backpressure on one beat,
    // optional start pokes mid-run; checks every beat against exp_d/exp_s.
    task automatic run_job(input string tag, input int hold_beat, input int hold_len,
                           input bit poke, input bit chk_lat);
        int beat = 0, cyc = 0, first = -1, done_cyc = -1, held = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.start = poke && (cyc == 8 || cyc == 17);
            if (poke && (cyc == 9 || cyc == 18))
                check({tag, "_busy_poke"}, int'(bus.busy), 1);
            if (bus.done) begin
                done_cyc = cyc;
                check({tag, "_done_busy"},  int'(bus.busy), 0);
                check({tag, "_done_valid"}, int'(bus.out_valid), 0);
                break;
            end
            bus.out_ready = !(beat == hold_beat && held < hold_len);
            if (bus.out_valid) begin
                if (first < 0) first = cyc;
                if (beat >= NH) begin
                    check({tag, "_extra_beat"}, beat, NH - 1);
                end else if (bus.out_ready) begin
                    check({tag, "_idx"},   int'(bus.out_idx), beat);
                    check({tag, "_delta"}, int'($signed(bus.out_delta)), exp_d[beat]);
                    check({tag, "_sat"},   int'(bus.sat_flag), exp_s[beat]);
                    beat++;
                end else begin
                    held++;
                    check({tag, "_hold_idx"},   int'(bus.out_idx), hold_beat);
                    check({tag, "_hold_delta"}, int'($signed(bus.out_delta)), exp_d[hold_beat]);
                end
            end
            if (cyc > 300) begin
                check({tag, "_timeout"}, cyc, -1);
                break;
            end
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        check({tag, "_beats"}, beat, NH);
        if (hold_beat >= 0) check({tag, "_held"}, held, hold_len);
        if (chk_lat) begin
            check({tag, "_first_valid"}, first, 5);
            check({tag, "_done_cycle"},  done_cyc, 26);
        end
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        set_data(0, 0, 0);
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal: acc=12288, s=192, d=16 -> 48
        set_data(64, 64, 32);
        set_exp(48, 0);
        run_job("nominal", -1, 0, 1'b0, 1'b1);

        set_data(64, -64, 32);
        set_exp(-48, 0);
        run_job("sign", -1, 0, 1'b0, 1'b0);

        // W[0][2] = -64 -> acc=4096, s=64 -> 16
        set_data(64, 64, 32);
        bus.weight_i[2*W +: W] = 10'h3C0;
        set_exp(48, 0);
        exp_d[2] = 16;
        run_job("mixed", -1, 0, 1'b0, 1'b0);

        // 511*511*3 >>> 6 = 12240, *16 >>> 6 = 3060 -> clip
        set_data(511, 511, 32);
        set_exp(511, 1);
        run_job("sat_pos", -1, 0, 1'b0, 1'b0);

        // -784896 >>> 6 = -12264, *16 >>> 6 = -3066 -> clip
        set_data(511, -512, 32);
        set_exp(-512, 1);
        run_job("sat_neg", -1, 0, 1'b0, 1'b0);

        set_data(64, 64, 32);
        bus.act_i = {10'd16, 10'd32, 10'd100, 10'd64, 10'd0};
        set_exp(0, 0);
        exp_d[3] = 48;
        exp_d[4] = 36;
        run_job("act_edge", -1, 0, 1'b0, 1'b0);

        set_data(64, 64, 32);
        set_exp(48, 0);
        run_job("bp", 2, 7, 1'b1, 1'b0);

        // Reset during the beat-1 MAC phase, then a fresh job.
        @(negedge clk);
        bus.start = 1'b1;
        repeat (7) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("mid_busy_before", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_data(64, -64, 32);
        set_exp(-48, 0);
        run_job("after_reset", -1, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hidden_delta_engine.md
Name: hidden_delta_engine

Overview:
- Sequential, parametrised successor to the combinational hidden-layer delta calculator in the weight-optimisation path.
- For each hidden neuron j it computes delta0[j] = f'(out0[j]) * sum_k delta1[k]*W[k][j] in signed fixed point, with f'(a) = a*(1-a).
- Uses one shared multiplier and a start/busy/done control interface.
- Results leave on a valid/ready stream, one neuron per beat, into the weight-update stage.

Parameters:
- W, 10, data width of every operand and result (signed two's complement).
- FRAC, 6, fractional bits; fixed-point ONE = 2**FRAC.
- N_HIDDEN, 5, number of hidden neurons (outputs produced).
- N_OUT, 3, number of next-layer neurons (terms accumulated per hidden neuron).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only while idle.
- delta1_i  in  N_OUT*W  next-layer deltas, signed; element k at bits [k*W +: W].
- weight_i  in  N_OUT*N_HIDDEN*W  signed weights; W[k][j] at bits [(k*N_HIDDEN+j)*W +: W].
- act_i  in  N_HIDDEN*W  hidden activations out0[j], unsigned, nominal range [0, ONE].
- busy  out  1  high from start acceptance until done.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_idx  out  clog2(N_HIDDEN) (min 1)  hidden neuron index of the beat.
- out_delta  out  W  signed delta0[out_idx].
- sat_flag  out  1  high with the beat if that result saturated.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset, async assert: state IDLE; busy, out_valid, done, sat_flag = 0; out_idx, out_delta = 0; accumulator and counters cleared. Reset mid-run abandons the job and no partial stream is resumed.
- IDLE: start=1 latches delta1_i, weight_i and act_i into internal registers. Sets j=0, k=0, acc=0, busy=1, then goes to MAC. Inputs may change after that edge.
- start while busy is ignored; there is no queueing.
- MAC: one term per cycle, acc += delta1[k]*W[k][j], with a full-precision product (2W bits). Accumulator width is 2W+clog2(N_OUT) and never overflows. After k=N_OUT-1, go to SCALE.
- SCALE, 1 cycle:
  - s = acc >>> FRAC (arithmetic shift, truncates toward -inf).
  - a = min(act[j], ONE); d = (a*(ONE-a)) >> FRAC.
  - r = (s*d) >>> FRAC.
  - Saturate r to [-(2**(W-1)), 2**(W-1)-1] and set sat flag if clipped.
  - Register out_delta, out_idx=j, sat_flag. Go to EMIT.
- EMIT: out_valid=1. out_delta, out_idx and sat_flag hold stable while out_ready=0.
- On out_valid&&out_ready: if j<N_HIDDEN-1, then j++, k=0, acc=0, out_valid drops next cycle, back to MAC. Otherwise go to DONE.
- DONE, 1 cycle: done=1, busy=0, out_valid=0, return to IDLE. start in the DONE cycle is ignored; start is accepted from the next cycle.
- Latency with out_ready held high:
  - first out_valid asserts N_OUT+2 cycles after the start edge;
  - beat spacing is N_OUT+2 cycles;
  - done occurs one cycle after the last handshake.
  - Defaults: first beat at cycle 5, done at cycle 26.
- Boundaries:
  - act=0 or act>=ONE gives d=0 and delta 0, not saturated.
  - N_OUT=1 and N_HIDDEN=1 are legal.
  - Backpressure of any length is lossless.

Decomposition:
- Package hidden_delta_pkg holds:
  - state enum {IDLE, MAC, SCALE, EMIT, DONE};
  - localparams ONE and ACC_W;
  - function sat_w(value, width) returning the clipped value and a flag.
- One sub-module, fxp_deriv_scale: combinational SCALE datapath (s, d, r, saturation). Registered by the parent so it can be unit-tested alone.
- The FSM, MAC and stream logic live in the parent.

Test Plan:
- Nominal (defaults, out_ready=1): all weights 64, all delta1 64, all act 32 -> five beats idx 0..4, each out_delta=48 (0.75), sat_flag=0. First out_valid at cycle 5, done at cycle 26.
- Sign: weights -64, delta1 64, act 32 -> each out_delta=-48. Mixed: W[0][2]=-64, others 64 -> idx2 delta=16, others 48.
- Saturation: weights 511, delta1 511, act 32 -> raw 3060 clipped to 511 with sat_flag=1. Weights -512, delta1 511 -> -512, sat_flag=1.
- Derivative edges: act = {0, 64, 100, 32, 16} -> deltas {0, 0, 0, 48, 36} (for act=16: d=12, 192*12>>6=36), no saturation.
- Handshake: out_ready low for 7 cycles on beat 2 -> out_valid, out_idx=2 and out_delta stable throughout, no beat lost or duplicated. start pulsed during the run -> ignored, busy unchanged.
- Reset mid-run: rst_n low during beat-1 MAC -> all outputs 0 immediately. After release and a new start, a full fresh 5-beat stream with correct values.
